post_commit_store_buffer: RTL and testbench

- FIFO of committed stores between the store queue (at ROB commit) and the data-cache port.
- Accepts one word-aligned, byte-masked store per cycle from commit and drains stores to dmem in order, one outstanding request at a time.
- Provides combinational byte-granular store-to-load forwarding to the load path, so committed-but-undrained data is visible to younger loads.

---
 rtl/post_commit_store_buffer.sv | 175 +++++++++++++++++
 tb/tb_post_commit_store_buffer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/post_commit_store_buffer.sv
// post_commit_store_buffer
// In-order buffer of committed stores sitting between ROB commit and the
// data-cache write port. Stores drain one at a time. Younger loads can
// read committed but not yet drained bytes through combinational
// store-to-load forwarding.
// Optional build macro: PCSB_COALESCE_EN. When it is defined, a store to
// the same word as the youngest entry merges into that entry instead of
// allocating a new one.

module post_commit_store_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [31:0]      enq_addr,
  input  logic [3:0]       enq_wmask,
  input  logic [31:0]      enq_wdata,
  output logic [31:0]      dmem_addr,
  output logic [3:0]       dmem_rmask,
  output logic [3:0]       dmem_wmask,
  output logic [31:0]      dmem_wdata,
  input  logic             dmem_resp,
  input  logic [31:0]      ld_addr,
  input  logic [3:0]       ld_rmask,
  output logic [31:0]      fwd_data,
  output logic [3:0]       fwd_mask,
  output logic             fwd_full,
  output logic             ld_conflict,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } pcsb_entry_t;

  typedef enum logic {IDLE, REQ} state_t;

  pcsb_entry_t      entries_q [DEPTH];
  pcsb_entry_t      entries_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  state_t           state_q, state_d;

  logic [PTR_W-1:0] youngest_idx;
  logic [PTR_W-1:0] fwd_idx;
  logic [3:0]       fwd_cover;
  logic [31:0]      fwd_raw;
  logic             full;
  logic             merge_hit;
  logic             enq_fire;
  logic             do_merge;
  logic             do_alloc;
  logic             do_pop;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^{enq_addr[1:0], ld_addr[1:0]};

  // Accept/merge/pop decisions. The full check uses registered occupancy only, so a same-cycle pop never opens a slot.
  always_comb begin
    full         = (count_q == CNT_W'(DEPTH));
    youngest_idx = tail_q - PTR_W'(1);
`ifdef PCSB_COALESCE_EN
    merge_hit = (count_q != '0) && entries_q[youngest_idx].valid &&
                (entries_q[youngest_idx].addr[31:2] == enq_addr[31:2]) &&
                !((state_q == REQ) && (youngest_idx == head_q));
`else
    merge_hit = 1'b0;
`endif
    enq_ready = !full || merge_hit;
    enq_fire  = enq_valid && enq_ready && (enq_wmask != 4'b0000);
    do_merge  = enq_fire && merge_hit;
    do_alloc  = enq_fire && !merge_hit;
    do_pop    = (state_q == REQ) && dmem_resp;
  end

  // Next storage, pointers and occupancy: retire the head, merge into the youngest entry, or allocate at the tail.
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    if (do_pop) begin
      entries_d[head_q].valid = 1'b0;
      head_d = head_q + PTR_W'(1);
    end
    if (do_merge) begin
      for (int l = 0; l < 4; l++) begin
        if (enq_wmask[l]) begin
          entries_d[youngest_idx].wdata[8*l +: 8] = enq_wdata[8*l +: 8];
        end
      end
      entries_d[youngest_idx].wmask = entries_q[youngest_idx].wmask | enq_wmask;
    end
    if (do_alloc) begin
      entries_d[tail_q].valid = 1'b1;
      entries_d[tail_q].addr  = {enq_addr[31:2], 2'b00};
      entries_d[tail_q].wmask = enq_wmask;
      entries_d[tail_q].wdata = enq_wdata;
      tail_d = tail_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(do_alloc) - CNT_W'(do_pop);
  end

  // Drain next state. It looks at post-update occupancy, so a fresh entry reaches dmem next cycle and drains run back to back.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (count_d != '0) state_d = REQ;
      REQ:  if (count_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Drain outputs: the head entry is presented and held until dmem_resp.
  always_comb begin
    dmem_addr  = entries_q[head_q].addr;
    dmem_wdata = entries_q[head_q].wdata;
    dmem_wmask = (state_q == REQ) ? entries_q[head_q].wmask : 4'b0000;
    dmem_rmask = 4'b0000;
    empty      = (count_q == '0);
    count      = count_q;
  end

  // Forwarding: walk from oldest to youngest so the youngest matching writer of each lane wins.
  always_comb begin
    fwd_cover = 4'b0000;
    fwd_raw   = 32'h0;
    fwd_idx   = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PTR_W'(i);
      if (entries_q[fwd_idx].valid && (entries_q[fwd_idx].addr[31:2] == ld_addr[31:2])) begin
        for (int l = 0; l < 4; l++) begin
          if (entries_q[fwd_idx].wmask[l]) begin
            fwd_cover[l]       = 1'b1;
            fwd_raw[8*l +: 8]  = entries_q[fwd_idx].wdata[8*l +: 8];
          end
        end
      end
    end
    fwd_mask = fwd_cover & ld_rmask;
    fwd_data = 32'h0;
    for (int l = 0; l < 4; l++) begin
      if (fwd_mask[l]) fwd_data[8*l +: 8] = fwd_raw[8*l +: 8];
    end
    fwd_full    = (fwd_mask == ld_rmask) && (ld_rmask != 4'b0000);
    ld_conflict = (fwd_mask != 4'b0000) && !fwd_full;
  end

  // State register with synchronous reset; a dmem_resp in the reset cycle is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
    end
  end

endmodule

// File: tb/tb_post_commit_store_buffer.sv
// tb_post_commit_store_buffer
// Directed and randomized stimulus for post_commit_store_buffer. The bench
// checks the DUT against a queue-based reference model of committed stores.
// Build macro PCSB_COALESCE_EN selects the coalescing reference behaviour.

module tb_post_commit_store_buffer;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst;
  logic             enq_valid;
  logic             enq_ready;
  logic [31:0]      enq_addr;
  logic [3:0]       enq_wmask;
  logic [31:0]      enq_wdata;
  logic [31:0]      dmem_addr;
  logic [3:0]       dmem_rmask;
  logic [3:0]       dmem_wmask;
  logic [31:0]      dmem_wdata;
  logic             dmem_resp;
  logic [31:0]      ld_addr;
  logic [3:0]       ld_rmask;
  logic [31:0]      fwd_data;
  logic [3:0]       fwd_mask;
  logic             fwd_full;
  logic             ld_conflict;
  logic             empty;
  logic [CNT_W-1:0] count;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } store_t;

  store_t q[$];
  int     checks = 0;
  int     errors = 0;

  post_commit_store_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_addr(enq_addr),
    .enq_wmask(enq_wmask), .enq_wdata(enq_wdata),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_resp(dmem_resp),
    .ld_addr(ld_addr), .ld_rmask(ld_rmask), .fwd_data(fwd_data),
    .fwd_mask(fwd_mask), .fwd_full(fwd_full), .ld_conflict(ld_conflict),
    .empty(empty), .count(count)
  );

  // Free-running core clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it when observed and expected differ
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // A store merges only into the youngest entry, and only when that entry is not the one being drained
  function automatic logic mergeHit(input logic [31:0] a);
`ifdef PCSB_COALESCE_EN
    return (q.size() >= 2) && (q[q.size()-1].addr == {a[31:2], 2'b00});
`else
    return 1'b0;
`endif
  endfunction

  // Compare all outputs against the model for the inputs currently applied
  task automatic compareAll();
    int          n;
    logic [3:0]  cov;
    logic [3:0]  fm;
    logic [31:0] fd;
    n = q.size();
    checkOutput("count", 32'(count), 32'(n));
    checkOutput("empty", 32'(empty), 32'(n == 0));
    checkOutput("enq_ready", 32'(enq_ready), 32'((n != DEPTH) || mergeHit(enq_addr)));
    checkOutput("dmem_rmask", 32'(dmem_rmask), 32'h0);
    if (n != 0) begin
      checkOutput("dmem_addr", dmem_addr, q[0].addr);
      checkOutput("dmem_wmask", 32'(dmem_wmask), 32'(q[0].mask));
      checkOutput("dmem_wdata", dmem_wdata, q[0].data);
    end else begin
      checkOutput("dmem_wmask_idle", 32'(dmem_wmask), 32'h0);
    end
    cov = 4'b0000;
    fd  = 32'h0;
    foreach (q[i]) begin
      if (q[i].addr[31:2] == ld_addr[31:2]) begin
        for (int l = 0; l < 4; l++) begin
          if (q[i].mask[l]) begin
            cov[l] = 1'b1;
            fd[8*l +: 8] = q[i].data[8*l +: 8];
          end
        end
      end
    end
    fm = cov & ld_rmask;
    for (int l = 0; l < 4; l++) if (!fm[l]) fd[8*l +: 8] = 8'h00;
    checkOutput("fwd_mask", 32'(fwd_mask), 32'(fm));
    checkOutput("fwd_data", fwd_data, fd);
    checkOutput("fwd_full", 32'(fwd_full), 32'((fm == ld_rmask) && (ld_rmask != 4'b0000)));
    checkOutput("ld_conflict", 32'(ld_conflict), 32'((fm != 4'b0000) && (fm != ld_rmask)));
  endtask

  // Drive one cycle of inputs, check at the falling edge, then advance the model at the rising edge
  task automatic applyStimulus(input logic ev, input logic [31:0] ea, input logic [3:0] em,
                               input logic [31:0] ed, input logic rs,
                               input logic [31:0] la, input logic [3:0] lm);
    logic   mh;
    logic   fire;
    logic   pop;
    store_t s;
    enq_valid = ev; enq_addr = ea; enq_wmask = em; enq_wdata = ed;
    dmem_resp = rs; ld_addr = la; ld_rmask = lm;
    @(negedge clk);
    compareAll();
    mh   = mergeHit(ea);
    fire = ev && ((q.size() != DEPTH) || mh) && (em != 4'b0000);
    pop  = rs && (q.size() != 0);
    @(posedge clk);
    if (fire && mh) begin
      for (int l = 0; l < 4; l++) if (em[l]) q[q.size()-1].data[8*l +: 8] = ed[8*l +: 8];
      q[q.size()-1].mask = q[q.size()-1].mask | em;
    end
    if (pop) void'(q.pop_front());
    if (fire && !mh) begin
      s.addr = {ea[31:2], 2'b00};
      s.mask = em;
      s.data = ed;
      q.push_back(s);
    end
    #1;
  endtask

  // One-cycle synchronous reset with a possibly stray enqueue/resp, then check the reset state
  task automatic resetDut(input logic rs);
    logic [31:0] a;
    a = 32'h0000_8000 | ($urandom & 32'hFC);
    rst = 1'b1; dmem_resp = rs; enq_valid = 1'b1; enq_addr = a;
    enq_wmask = 4'hF; enq_wdata = $urandom;
    @(posedge clk);
    #1;
    rst = 1'b0; dmem_resp = 1'b0; enq_valid = 1'b0;
    q.delete();
    ld_addr = a; ld_rmask = 4'hF;
    #2;
    checkOutput("rst_ready", 32'(enq_ready), 32'h1);
    checkOutput("rst_empty", 32'(empty), 32'h1);
    checkOutput("rst_count", 32'(count), 32'h0);
    checkOutput("rst_dmem_wmask", 32'(dmem_wmask), 32'h0);
    checkOutput("rst_fwd_mask", 32'(fwd_mask), 32'h0);
    checkOutput("rst_fwd_full", 32'(fwd_full), 32'h0);
    checkOutput("rst_conflict", 32'(ld_conflict), 32'h0);
  endtask

  // Keep acknowledging until the model is empty (bounded)
  task automatic drainAll();
    for (int i = 0; i < 4 * DEPTH && q.size() != 0; i++) begin
      applyStimulus(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0, 4'h0);
    end
    applyStimulus(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0);
    checkOutput("drain_empty", 32'(empty), 32'h1);
  endtask

  // Test sequence: directed cases first, then randomized traffic with occasional mid-drain resets
  initial begin
    logic [31:0] pool [4];
    rst = 1'b1; enq_valid = 1'b0; enq_addr = 32'h0; enq_wmask = 4'h0; enq_wdata = 32'h0;
    dmem_resp = 1'b0; ld_addr = 32'h0; ld_rmask = 4'h0;
    pool[0] = 32'h0000_2000; pool[1] = 32'h0000_2004;
    pool[2] = 32'h0000_3000; pool[3] = 32'h0000_4000;
    @(posedge clk);
    resetDut(1'b0);

    // Held request until resp, then empty
    applyStimulus(1'b1, 32'h1000_0006, 4'b1100, 32'hBEEF_0000, 1'b0, 32'h0, 4'h0);
    enq_valid = 1'b0;
    #2;
    checkOutput("tp1_addr", dmem_addr, 32'h1000_0004);
    checkOutput("tp1_wmask", 32'(dmem_wmask), 32'hC);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0);
    applyStimulus(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0, 4'h0);
    #2;
    checkOutput("tp1_empty", 32'(empty), 32'h1);

    // Fill to DEPTH; an extra store is refused; one resp reopens
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b1, 32'h5000 + 32'(4 * i), 4'hF, $urandom, 1'b0, 32'h0, 4'h0);
    applyStimulus(1'b1, 32'h5010, 4'hF, 32'h1234_5678, 1'b0, 32'h0, 4'h0);
    enq_valid = 1'b0;
    #2;
    checkOutput("tp2_count", 32'(count), 32'(DEPTH));
    checkOutput("tp2_ready", 32'(enq_ready), 32'h0);
    applyStimulus(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0, 4'h0);
    #2;
    checkOutput("tp2_count_after", 32'(count), 32'(DEPTH - 1));
    checkOutput("tp2_ready_after", 32'(enq_ready), 32'h1);
    drainAll();

    // Youngest writer wins per lane
    applyStimulus(1'b1, 32'h2000, 4'b1111, 32'h1122_3344, 1'b0, 32'h0, 4'h0);
    applyStimulus(1'b1, 32'h2000, 4'b0001, 32'h0000_00AA, 1'b0, 32'h0, 4'h0);
    enq_valid = 1'b0; ld_addr = 32'h2000; ld_rmask = 4'hF;
    #2;
    checkOutput("tp3_data", fwd_data, 32'h1122_33AA);
    checkOutput("tp3_full", 32'(fwd_full), 32'h1);
    drainAll();

    // Partial coverage is a conflict
    applyStimulus(1'b1, 32'h3000, 4'b0011, 32'hAAAA_5566, 1'b0, 32'h0, 4'h0);
    enq_valid = 1'b0; ld_addr = 32'h3000; ld_rmask = 4'hF;
    #2;
    checkOutput("tp4_mask", 32'(fwd_mask), 32'h3);
    checkOutput("tp4_conflict", 32'(ld_conflict), 32'h1);
    checkOutput("tp4_full", 32'(fwd_full), 32'h0);
    drainAll();

    // Enqueue and pop together keep the count and order
    applyStimulus(1'b1, 32'h6000, 4'hF, 32'hA0A0_A0A0, 1'b0, 32'h0, 4'h0);
    applyStimulus(1'b1, 32'h6004, 4'hF, 32'hB1B1_B1B1, 1'b0, 32'h0, 4'h0);
    applyStimulus(1'b1, 32'h6008, 4'hF, 32'hC2C2_C2C2, 1'b1, 32'h0, 4'h0);
    enq_valid = 1'b0; dmem_resp = 1'b0;
    #2;
    checkOutput("tp5_count", 32'(count), 32'h2);
    checkOutput("tp5_head", dmem_addr, 32'h6004);
    drainAll();

`ifdef PCSB_COALESCE_EN
    // Two stores to one word merge behind a busy head
    applyStimulus(1'b1, 32'h7000, 4'hF, 32'h7777_7777, 1'b0, 32'h0, 4'h0);
    applyStimulus(1'b1, 32'h4000, 4'b0001, 32'h0000_0011, 1'b0, 32'h0, 4'h0);
    applyStimulus(1'b1, 32'h4000, 4'b0100, 32'h0022_0000, 1'b0, 32'h0, 4'h0);
    enq_valid = 1'b0;
    #2;
    checkOutput("co_count", 32'(count), 32'h2);
    applyStimulus(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0, 4'h0);
    #2;
    checkOutput("co_wmask", 32'(dmem_wmask), 32'h5);
    checkOutput("co_wdata", dmem_wdata, 32'h0022_0011);
    drainAll();
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      if (($urandom % 80) == 0) begin
        resetDut(1'b1);
      end else begin
        applyStimulus(($urandom % 2) == 0,
                      pool[$urandom % 4] | 32'($urandom % 4),
                      4'($urandom), $urandom,
                      ($urandom % 5) < 2,
                      pool[$urandom % 4] | 32'($urandom % 4),
                      4'($urandom));
      end
    end
    drainAll();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
